mem_ctrl: RTL and testbench

Shared memory controller: the responder side of the CPU's memory request interface. Serves 32-bit word reads for the instruction-fetch port and byte-masked reads and writes for the data port. Serialises each access onto one byte-wide synchronous RAM. Drives the busy/done/data handshake that the fetch and memory stages poll while stalling.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl_fetch_buf.sv | 53 +++++
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// bus widths and the write-lane selector.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        RD_LAST = 2'd2,
        WR      = 2'd3
    } state_e;

    function automatic logic [BYTE_W-1:0] byte_lane(input logic [DATA_W-1:0] w,
                                                    input logic [1:0]        idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_fetch_buf.sv
// One-entry cache of the last completed instruction fetch {valid, addr, word}.
// Only instantiated when MEM_CTRL_FETCH_BUF_EN is defined.
module mem_ctrl_fetch_buf
    import mem_ctrl_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              fill_i,
    input  logic [AW-1:0]     fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic [AW-1:0]     lookup_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            addr_d  = fill_addr_i;
            data_d  = fill_data_i;
        end
        // Any data write may alias the buffered word, so drop it.
        if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (addr_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller serialising fetch and data-port word accesses onto a
// byte-wide synchronous RAM. Define MEM_CTRL_FETCH_BUF_EN for the fetch buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_re,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_busy,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_wmask,
    output logic              dm_busy,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [BYTE_W-1:0] ram_wdata,
    input  logic [BYTE_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              port_dm_q, port_dm_d;
    logic [23:0]       rbuf_q, rbuf_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;

    logic              buf_hit, buf_clr, buf_fill;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] rd_word;

    // Byte 3 is never parked in rbuf; it goes straight from the RAM into the result.
    assign rd_word = {ram_rdata, rbuf_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        port_dm_d  = port_dm_q;
        rbuf_d     = rbuf_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        buf_clr    = 1'b0;
        buf_fill   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_re || dm_we) begin
                    addr_d    = dm_addr[RAM_AW-1:0];
                    wdata_d   = dm_wdata;
                    wmask_d   = dm_wmask;
                    port_dm_d = 1'b1;
                    cnt_d     = 2'd0;
                    state_d   = dm_we ? WR : RD;
                    buf_clr   = dm_we;
                end else if (if_re) begin
                    if (buf_hit) begin
                        if_done_d = 1'b1;
                        if_data_d = buf_data;
                    end else begin
                        addr_d    = if_addr[RAM_AW-1:0];
                        port_dm_d = 1'b0;
                        cnt_d     = 2'd0;
                        state_d   = RD;
                    end
                end
            end
            RD: begin
                // RAM data lags the address by one cycle: capture byte cnt-1.
                case (cnt_q)
                    2'd1:    rbuf_d[7:0]   = ram_rdata;
                    2'd2:    rbuf_d[15:8]  = ram_rdata;
                    2'd3:    rbuf_d[23:16] = ram_rdata;
                    default: ;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = RD_LAST;
                end
            end
            RD_LAST: begin
                state_d = IDLE;
                if (port_dm_q) begin
                    dm_rdata_d = rd_word;
                    dm_done_d  = 1'b1;
                end else begin
                    if_data_d = rd_word;
                    if_done_d = 1'b1;
                    buf_fill  = 1'b1;
                end
            end
            WR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = IDLE;
                    dm_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            port_dm_q  <= 1'b0;
            rbuf_q     <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            port_dm_q  <= port_dm_d;
            rbuf_q     <= rbuf_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    // The write strobe is gated by rst so an aborted write stops in the reset cycle.
    assign ram_addr  = (state_q == RD || state_q == WR) ? addr_q + RAM_AW'(cnt_q) : '0;
    assign ram_we    = (state_q == WR) && wmask_q[cnt_q] && !rst;
    assign ram_wdata = (state_q == WR) ? byte_lane(wdata_q, cnt_q) : '0;

    assign if_busy     = (state_q != IDLE);
    assign dm_busy     = (state_q != IDLE);
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign if_data     = if_data_q;
    assign dm_rdata    = dm_rdata_q;
    assign dbg_state_o = state_q;

`ifdef MEM_CTRL_FETCH_BUF_EN
    mem_ctrl_fetch_buf #(
        .AW(RAM_AW)
    ) u_fetch_buf (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (buf_clr),
        .fill_i        (buf_fill),
        .fill_addr_i   (addr_q),
        .fill_data_i   (rd_word),
        .lookup_addr_i (if_addr[RAM_AW-1:0]),
        .hit_o         (buf_hit),
        .data_o        (buf_data)
    );
`else
    logic unused_buf_ctrl;
    assign buf_hit         = 1'b0;
    assign buf_data        = '0;
    assign unused_buf_ctrl = buf_clr ^ buf_fill;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[ADDR_W-1:RAM_AW], dm_addr[ADDR_W-1:RAM_AW]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl against a word-level reference memory model,
// plus directed fetch, masked-write, arbitration, reset-abort and wrap cases.
module tb_mem_ctrl;

    localparam int AW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_re, dm_re, dm_we;
    logic [31:0]   if_addr, dm_addr, dm_wdata;
    logic [3:0]    dm_wmask;
    logic          if_busy, if_done, dm_busy, dm_done;
    logic [31:0]   if_data, dm_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata, ram_rdata;
    logic [1:0]    dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_re       (if_re),
        .if_addr     (if_addr),
        .if_busy     (if_busy),
        .if_done     (if_done),
        .if_data     (if_data),
        .dm_re       (dm_re),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_wmask    (dm_wmask),
        .dm_busy     (dm_busy),
        .dm_done     (dm_done),
        .dm_rdata    (dm_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .dbg_state_o (dbg_state)
    );

    // byte-wide synchronous RAM
    logic [7:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // reference model: what memory should hold and what each port last returned
    logic [7:0]    ref_mem [DEPTH];
    logic [31:0]   exp_if_data, exp_dm_rdata;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [31:0]   exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        logic [31:0]   w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            p = a + AW'(i);
            w[8*i +: 8] = ref_mem[p];
        end
        return w;
    endfunction

    task automatic set_byte(input logic [AW-1:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // driver: one complete access, request held until its done pulse
    task automatic run_access(input bit is_fetch, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask);
        int            exp_lat, lat;
        bit            busy_bad;
        logic [AW-1:0] a, p;
        logic [31:0]   word;
        a = addr[AW-1:0];
        word = ref_word(a);
        busy_bad = 1'b0;
        if (is_fetch) begin
            exp_lat = 6;
`ifdef MEM_CTRL_FETCH_BUF_EN
            if (buf_valid && buf_addr == a) exp_lat = 1;
`endif
            exp_q.push_back(word);
            if_addr = addr;
            if_re   = 1'b1;
        end else begin
            exp_lat  = we ? 5 : 6;
            if (!we) exp_q.push_back(word);
            dm_addr  = addr;
            dm_wdata = wdata;
            dm_wmask = mask;
            dm_we    = we;
            dm_re    = we ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (is_fetch ? if_done : dm_done) lat = n;
            else if (!if_busy || !dm_busy) busy_bad = 1'b1;
            if (is_fetch ? dm_done : if_done) busy_bad = 1'b1;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_run", 32'(busy_bad), 32'd0);
        if (lat != 0) begin
            check_eq("busy_in_done", {30'd0, if_busy, dm_busy}, 32'd0);
            if (is_fetch) check_eq("if_data", if_data, exp_q.pop_front());
            else if (!we) check_eq("dm_rdata", dm_rdata, exp_q.pop_front());
        end else begin
            exp_q.delete();
        end
        if_re = 1'b0;
        dm_re = 1'b0;
        dm_we = 1'b0;
        if (is_fetch) begin
            exp_if_data = word;
            if (exp_lat == 6) begin
                buf_valid = 1'b1;
                buf_addr  = a;
            end
        end else if (!we) begin
            exp_dm_rdata = word;
        end else begin
            for (int i = 0; i < 4; i++) begin
                p = a + AW'(i);
                if (mask[i]) ref_mem[p] = wdata[8*i +: 8];
            end
            buf_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("done_pulse", {30'd0, if_done, dm_done}, 32'd0);
        check_eq("if_data_held", if_data, exp_if_data);
        check_eq("dm_rdata_held", dm_rdata, exp_dm_rdata);
        if (!is_fetch && we) begin
            for (int i = 0; i < 4; i++) begin
                p = a + AW'(i);
                check_eq("ram_byte", {24'd0, ram[p]}, {24'd0, ref_mem[p]});
            end
        end
    endtask

    initial begin
        logic [7:0]  old1, old3, b1, b2, b3;
        logic [31:0] wd, wf, got_d, got_f;
        int          dm_lat, if_lat;
        bit          stray;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst = 1'b1;
        if_re = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
        exp_if_data = '0; exp_dm_rdata = '0; buf_valid = 1'b0; buf_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values
        check_eq("rst_busy", {30'd0, if_busy, dm_busy}, 32'd0);
        check_eq("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        check_eq("rst_if_data", if_data, 32'd0);
        check_eq("rst_dm_rdata", dm_rdata, 32'd0);
        check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check_eq("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        check_eq("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);

        // fetch of a known word
        set_byte(16'h0100, 8'h13); set_byte(16'h0101, 8'h00);
        set_byte(16'h0102, 8'h00); set_byte(16'h0103, 8'h00);
        run_access(1'b1, 1'b0, 32'h0000_0100, '0, '0);
        check_eq("fetch_word", if_data, 32'h0000_0013);
        run_access(1'b1, 1'b0, 32'h0000_0100, '0, '0);

        // masked write
        old1 = ram[16'h0201];
        old3 = ram[16'h0203];
        run_access(1'b0, 1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101);
        check_eq("mw_b0", {24'd0, ram[16'h0200]}, 32'h0000_00DD);
        check_eq("mw_b1", {24'd0, ram[16'h0201]}, {24'd0, old1});
        check_eq("mw_b2", {24'd0, ram[16'h0202]}, 32'h0000_00BB);
        check_eq("mw_b3", {24'd0, ram[16'h0203]}, {24'd0, old3});
        run_access(1'b1, 1'b0, 32'h0000_0100, '0, '0);

        // simultaneous fetch and data read: data first, fetch accepted on dm_done edge
        wd = ref_word(16'h0010);
        wf = ref_word(16'h0000);
        dm_addr = 32'h10; dm_re = 1'b1;
        if_addr = 32'h0;  if_re = 1'b1;
        dm_lat = 0; if_lat = 0; got_d = '0; got_f = '0;
        for (int n = 1; n <= 30 && if_lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (dm_done && dm_lat == 0) begin
                dm_lat = n; got_d = dm_rdata; dm_re = 1'b0;
            end
            if (if_done) begin
                if_lat = n; got_f = if_data; if_re = 1'b0;
            end
        end
        if_re = 1'b0; dm_re = 1'b0;
        check_eq("sim_dm_lat", 32'(dm_lat), 32'd6);
        check_eq("sim_if_lat", 32'(if_lat), 32'd12);
        check_eq("sim_dm_data", got_d, wd);
        check_eq("sim_if_data", got_f, wf);
        exp_dm_rdata = wd; exp_if_data = wf; buf_valid = 1'b1; buf_addr = '0;
        @(posedge clk);
        #1;

        // reset in the second cycle of a full-mask write
        b1 = ram[16'h0301]; b2 = ram[16'h0302]; b3 = ram[16'h0303];
        dm_addr = 32'h300; dm_wdata = 32'h1122_3344; dm_wmask = 4'hF; dm_we = 1'b1;
        @(posedge clk);
        #1;
        check_eq("wr_we_cycle1", {31'd0, ram_we}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; dm_we = 1'b0;
        #1;
        check_eq("rst_mid_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (dm_done || if_done || ram_we || dm_busy) stray = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("abort_quiet", 32'(stray), 32'd0);
        check_eq("abort_b0", {24'd0, ram[16'h0300]}, 32'h0000_0044);
        check_eq("abort_b123", {8'd0, ram[16'h0303], ram[16'h0302], ram[16'h0301]}, {8'd0, b3, b2, b1});
        check_eq("abort_dm_rdata", dm_rdata, 32'd0);
        check_eq("abort_if_data", if_data, 32'd0);
        ref_mem[16'h0300] = 8'h44;
        exp_if_data = '0; exp_dm_rdata = '0; buf_valid = 1'b0;
        run_access(1'b0, 1'b0, 32'h0000_0300, '0, '0);

        // address wrap, upper request bits ignored
        set_byte(16'hFFFE, 8'h01); set_byte(16'hFFFF, 8'h02);
        set_byte(16'h0000, 8'h03); set_byte(16'h0001, 8'h04);
        run_access(1'b0, 1'b0, 32'h0001_FFFE, '0, '0);
        check_eq("wrap_word", dm_rdata, 32'h0403_0201);

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = 32'hFFF8 + 32'($urandom_range(0, 7));
            else a = 32'h100 + 32'($urandom_range(0, 63));
            if (kind == 0 && $urandom_range(0, 1) == 1) a = 32'h100;
            a = a | ($urandom() & 32'hFFFF_0000);
            run_access(kind == 0, kind == 2, a, $urandom(), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
